// File: rtl/mem_pkg.sv
// Shared definitions for the memory initiator.
// Contents:
//   state_t  - initiator FSM state encoding. The inverted-pattern states exist only when
//              MEM_INITIATOR_INV_PASS_EN is defined.
//   pattern  - test data generator: seed XOR addr, optionally inverted.
//              Operands are widened to 64 bits, so callers must keep WIDTH <= 64.
package mem_pkg;

`ifdef MEM_INITIATOR_INV_PASS_EN
   typedef enum logic [2:0] {
      StIdle, StWrite, StRead, StWriteInv, StReadInv, StDone
   } state_t;
`else
   typedef enum logic [2:0] {
      StIdle, StWrite, StRead, StDone
   } state_t;
`endif

   localparam int unsigned PatMaxWidth = 64;

   // Callers zero-extend seed and address into the 64-bit operands and truncate the result
   // back to their word width.
   function automatic logic [PatMaxWidth-1:0] pattern(input logic [PatMaxWidth-1:0] seed,
                                                      input logic [PatMaxWidth-1:0] a,
                                                      input logic                   inv);
      logic [PatMaxWidth-1:0] p;
      p = seed ^ a;
      return inv ? ~p : p;
   endfunction

endpackage

// File: rtl/mem_addr_seq.sv
// Address sequencer for the memory initiator.
// It walks the addresses 0..DEPTH-1 and wraps back to 0 after the last address.
// Ports:
//   clk      - clock, rising edge
//   res      - asynchronous active-low reset
//   clear    - synchronous return to address 0; takes priority over advance
//   advance  - step to the next address (driven by the handshake)
//   addr     - current address (registered)
//   addr_nxt - address that follows addr, wrapping to 0 after the last address
//   last     - high when addr is DEPTH-1
module mem_addr_seq #(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  clear,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [ADDR_WIDTH-1:0] addr_nxt,
   output logic                  last
);

   assign last     = (addr == ADDR_WIDTH'(DEPTH - 1));
   assign addr_nxt = last ? '0 : addr + ADDR_WIDTH'(1);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         addr <= '0;
      end else if (clear) begin
         addr <= '0;
      end else if (advance) begin
         addr <= addr_nxt;
      end
   end

endmodule

// File: rtl/mem_initiator.sv
// Memory test initiator.
// A run first writes the pattern seed^addr to every address 0..DEPTH-1. It then reads
// each address back and compares the data with the same pattern, counting mismatches
// and recording the address of the first one.
// If MEM_INITIATOR_INV_PASS_EN is defined, a second write/read pass follows using the
// inverted pattern, and errors from both passes accumulate in err_count.
// Ports:
//   clk, res        - clock (rising edge) and asynchronous active-low reset
//   start, seed     - start a run (accepted only in idle/done); seed is latched on start
//   busy, done      - run in progress / run finished; done holds until the next start
//   pass            - valid while done: high when no mismatches were seen
//   err_count       - number of mismatches, saturating at all-ones
//   first_err_addr  - address of the first mismatch, or 0 if there was none
//   wr_rd, valid, addr, wdata - request to the memory (wr_rd=1 means write); all registered
//   rdata, ready    - response from the memory; a transfer completes when valid and ready
module mem_initiator #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  start,
   input  logic [WIDTH-1:0]      seed,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH+1:0] err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic                  wr_rd,
   output logic                  valid,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [WIDTH-1:0]      wdata,
   input  logic [WIDTH-1:0]      rdata,
   input  logic                  ready
);

   import mem_pkg::*;

   state_t                  state_q;
   logic [WIDTH-1:0]        seed_q;
   logic                    drain_q;     // last read done; applying its compare result
   logic                    cmp_err_q;   // mismatch seen at the previous handshake
   logic [ADDR_WIDTH-1:0]   cmp_addr_q;
   logic                    hs;
   logic                    accept;
   logic                    last;
   logic                    inv_phase;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [WIDTH-1:0]        wdata_nxt;
   logic [WIDTH-1:0]        rd_exp;
   logic [ADDR_WIDTH+1:0]   err_nxt;
   logic [ADDR_WIDTH-1:0]   first_nxt;

   assign hs     = valid & ready;
   assign accept = start & ((state_q == StIdle) | (state_q == StDone));

`ifdef MEM_INITIATOR_INV_PASS_EN
   assign inv_phase = (state_q == StWriteInv) | (state_q == StReadInv);
`else
   assign inv_phase = 1'b0;
`endif

   assign wdata_nxt = WIDTH'(pattern(64'(seed_q), 64'(addr_nxt), inv_phase));
   assign rd_exp    = WIDTH'(pattern(64'(seed_q), 64'(addr), inv_phase));

   // The compare result is registered first, so the error counters trail the handshake
   // by one cycle. The drain cycle after the final read absorbs this delay.
   always_comb begin
      err_nxt   = err_count;
      first_nxt = first_err_addr;
      if (cmp_err_q) begin
         if (err_count != '1) err_nxt = err_count + (ADDR_WIDTH+2)'(1);
         if (err_count == '0) first_nxt = cmp_addr_q;
      end
   end

   mem_addr_seq #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_seq (
      .clk      (clk),
      .res      (res),
      .clear    (accept),
      .advance  (hs),
      .addr     (addr),
      .addr_nxt (addr_nxt),
      .last     (last)
   );

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q        <= StIdle;
         seed_q         <= '0;
         drain_q        <= 1'b0;
         cmp_err_q      <= 1'b0;
         cmp_addr_q     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         wr_rd          <= 1'b0;
         valid          <= 1'b0;
         wdata          <= '0;
      end else begin
         err_count      <= err_nxt;
         first_err_addr <= first_nxt;
         cmp_err_q      <= 1'b0;
         if (drain_q) begin
            drain_q <= 1'b0;
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_nxt == '0);
         end else begin
            case (state_q)
               StIdle, StDone: begin
                  if (start) begin
                     state_q        <= StWrite;
                     seed_q         <= seed;
                     busy           <= 1'b1;
                     done           <= 1'b0;
                     pass           <= 1'b0;
                     err_count      <= '0;
                     first_err_addr <= '0;
                     valid          <= 1'b1;
                     wr_rd          <= 1'b1;
                     wdata          <= seed;  // pattern at address 0
                  end
               end
`ifdef MEM_INITIATOR_INV_PASS_EN
               StWrite, StWriteInv: begin
`else
               StWrite: begin
`endif
                  if (hs) begin
                     if (last) begin
                        state_q <= (state_q == StWrite) ? StRead : state_t'(StRead + 3'd2);
                        wr_rd   <= 1'b0;
                        wdata   <= '0;
                     end else begin
                        wdata   <= wdata_nxt;
                     end
                  end
               end
`ifdef MEM_INITIATOR_INV_PASS_EN
               StRead, StReadInv: begin
`else
               StRead: begin
`endif
                  if (hs) begin
                     cmp_err_q  <= (rdata != rd_exp);
                     cmp_addr_q <= addr;
                     if (last) begin
`ifdef MEM_INITIATOR_INV_PASS_EN
                        if (state_q == StRead) begin
                           state_q <= StWriteInv;
                           wr_rd   <= 1'b1;
                           wdata   <= WIDTH'(pattern(64'(seed_q), 64'd0, 1'b1));
                        end else begin
                           valid   <= 1'b0;
                           drain_q <= 1'b1;
                        end
`else
                        valid   <= 1'b0;
                        drain_q <= 1'b1;
`endif
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
module tb_mem_initiator;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            res = 1'b0;
   logic            start = 1'b0;
   logic [WIDTH-1:0] seed = '0;
   logic            busy, done, pass, wr_rd, valid;
   logic [AW+1:0]   err_count;
   logic [AW-1:0]   first_err_addr, addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata = '0;
   logic            ready = 1'b0;

   typedef struct packed {
      logic            wr;
      logic [AW-1:0]   a;
      logic [WIDTH-1:0] d;
   } req_t;

   req_t            exp_q[$];
   logic [WIDTH-1:0] mem [DEPTH];
   int              tests = 0;
   int              fails = 0;
   int              wait_cycles = 0;
   int              corrupt_addr = -1;
   int              hs_count = 0;

   mem_initiator #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk            (clk),
      .res            (res),
      .start          (start),
      .seed           (seed),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .wr_rd          (wr_rd),
      .valid          (valid),
      .addr           (addr),
      .wdata          (wdata),
      .rdata          (rdata),
      .ready          (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Responder and scoreboard monitor. Both run on the falling edge, away from the DUT's
   // active edge.
   initial begin
      logic            held;
      req_t            saved;
      req_t            e;
      int              wcnt;
      held = 1'b0;
      wcnt = 0;
      saved = '0;
      forever begin
         @(negedge clk);
         if (!res) begin
            held  = 1'b0;
            wcnt  = 0;
            ready = 1'b0;
         end else begin
            if (held)
               check("req_stable", {31'd0, valid} << 0 | {8'd0, wr_rd, addr, wdata} << 1,
                     {31'd0, 1'b1} | {8'd0, saved} << 1);
            if (valid) begin
               if (wcnt < wait_cycles) begin
                  ready = 1'b0;
                  wcnt++;
               end else begin
                  ready = 1'b1;
                  wcnt  = 0;
               end
            end else begin
               ready = (wait_cycles == 0);
            end
            held  = valid && !ready;
            saved = '{wr: wr_rd, a: addr, d: wdata};
            if (valid && ready) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  check("unexpected_handshake", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  if (e.wr) check("req_write", {18'd0, wr_rd, addr, wdata}, {18'd0, e});
                  else      check("req_read", {26'd0, wr_rd, addr}, {26'd0, e.wr, e.a});
               end
               if (wr_rd) mem[addr] = wdata;
               else rdata = mem[addr] ^ ((int'(addr) == corrupt_addr) ? 8'h01 : 8'h00);
            end
         end
      end
   end

   task automatic push_run(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] p;
      exp_q.delete();
      hs_count = 0;
      for (int a = 0; a < DEPTH; a++) begin
         p = s ^ WIDTH'(a);
         exp_q.push_back('{wr: 1'b1, a: AW'(a), d: p});
      end
      for (int a = 0; a < DEPTH; a++) exp_q.push_back('{wr: 1'b0, a: AW'(a), d: '0});
   endtask

   task automatic run(input logic [WIDTH-1:0] s, input int waits, input int bad,
                      input bit pulse_rd, input bit exp_pass, input int exp_err,
                      input int exp_first, input bit chk_time);
      int cyc;
      bit pulsed;
      wait_cycles  = waits;
      corrupt_addr = bad;
      pulsed       = 1'b0;
      @(negedge clk);
      seed  = s;
      start = 1'b1;
      push_run(s);
      @(negedge clk);
      start = 1'b0;
      check("start_clears", {25'd0, done, err_count, first_err_addr, busy, valid},
            {25'd0, 1'b0, 7'd0, 5'd0, 1'b1, 1'b1});
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (pulse_rd && !pulsed && valid && !wr_rd && busy) begin
            start  = 1'b1;
            seed   = ~s;
            pulsed = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("done_reached", {31'd0, done}, 32'd1);
      if (chk_time) check("done_latency", cyc, 2 * DEPTH + 1);
      check("pass", {31'd0, pass}, {31'd0, exp_pass});
      check("err_count", {25'd0, err_count}, exp_err);
      check("first_err_addr", {27'd0, first_err_addr}, exp_first);
      check("handshakes", hs_count, 2 * DEPTH);
      check("queue_empty", exp_q.size(), 0);
      check("idle_after_done", {30'd0, valid, busy}, 32'd0);
   endtask

   initial begin
      int cyc;
      #12;
      check("reset_outputs",
            {2'd0, busy, done, pass, err_count, first_err_addr, wr_rd, valid, addr, wdata}, 0);
      @(negedge clk);
      res = 1'b1;

      run(8'hA5, 0, -1, 1'b0, 1'b1, 0, 0, 1'b1);
      run(8'h5A, 2, -1, 1'b0, 1'b1, 0, 0, 1'b0);
      run(8'hA5, 0, 5, 1'b0, 1'b0, 1, 5, 1'b1);
      // Start is accepted in DONE with the error counters still set; start is ignored in READ.
      run(8'h33, 0, -1, 1'b1, 1'b1, 0, 0, 1'b1);

      // Asynchronous reset in the middle of the write at address 10.
      wait_cycles  = 0;
      corrupt_addr = -1;
      @(negedge clk);
      seed  = 8'h77;
      start = 1'b1;
      push_run(8'h77);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(valid && wr_rd && addr == 5'd10) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_addr10", {31'd0, cyc < 200}, 32'd1);
      #2 res = 1'b0;
      #1;
      check("reset_valid_low", {31'd0, valid}, 32'd0);
      check("reset_mid_outputs",
            {2'd0, busy, done, pass, err_count, first_err_addr, wr_rd, valid, addr, wdata}, 0);
      exp_q.delete();
      @(negedge clk);
      res = 1'b1;
      run(8'hC3, 0, -1, 1'b0, 1'b1, 0, 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
